fcf_readout_arbiter: RTL

Round-robin readout scheduler between two fast-cluster-finder word sources and a single 32-bit serializer input. It buffers each source's 32-bit cluster words in a small per-source FIFO and grants the shared serializer port alternately. It also sequences the serializer's `enable` through an IDLE/RUN/DRAIN state machine. It sits between the cluster finder outputs (`to_serial`/`dataV` pairs) and the serializer, in the BCclk domain.

---
 rtl/fcf_readout_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fcf_readout_arbiter.sv
// fcf_readout_arbiter: round-robin readout of two cluster-finder word
// sources into one 32-bit serializer port, with per-source FIFOs.
//
// Ports:
//   BCclk, reset_n        clock, async active-low reset
//   control[1:0]          per-source write enable (bit i = source i)
//   din0/dataV0           source 0 word and valid
//   din1/dataV1           source 1 word and valid
//   ser_ready             serializer accepts the presented word
//   to_serial/dataV       registered word and valid toward serializer
//   enable                serializer enable (state != IDLE)
//   ovf0/ovf1, ovf_clr    sticky drop flags and their clear
//   fill0/fill1           FIFO occupancy
module fcf_readout_arbiter #(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FW = AW + 1
) (
    input  logic          BCclk,
    input  logic          reset_n,
    input  logic [1:0]    control,
    input  logic [31:0]   din0,
    input  logic          dataV0,
    input  logic [31:0]   din1,
    input  logic          dataV1,
    input  logic          ser_ready,
    input  logic          ovf_clr,
    output logic [31:0]   to_serial,
    output logic          dataV,
    output logic          enable,
    output logic          ovf0,
    output logic          ovf1,
    output logic [FW-1:0] fill0,
    output logic [FW-1:0] fill1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_enable;
    logic [31:0]   r_mem [2][DEPTH];
    logic [AW-1:0] r_wp [2];
    logic [AW-1:0] r_rp [2];
    logic [FW-1:0] r_fill [2];
    logic [1:0]    r_ovf;
    logic [31:0]   r_to_serial;
    logic          r_dv;
    logic          r_last;

    logic [1:0]    w_vin;
    logic [31:0]   w_din [2];
    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    logic [1:0]    w_wr;
    logic [1:0]    w_drop;
    logic [1:0]    w_rd;
    logic          w_load;
    logic          w_sel;

    assign w_vin    = {dataV1, dataV0};
    assign w_din[0] = din0;
    assign w_din[1] = din1;

    // Full/empty come from start-of-cycle occupancy, so a write into a
    // full FIFO is dropped even when that FIFO is read this cycle.
    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_wr    = '0;
        w_drop  = '0;
        for (int i = 0; i < 2; i++) begin
            w_full[i]  = (r_fill[i] == FW'(DEPTH));
            w_empty[i] = (r_fill[i] == '0);
            w_wr[i]    = w_vin[i] & control[i] & ~w_full[i];
            w_drop[i]  = w_vin[i] & control[i] & w_full[i];
        end
    end

    // Arbitration ignores control so buffered words always drain.
    assign w_load = (r_state != ST_IDLE) && (!r_dv || ser_ready)
                    && (w_empty != 2'b11);
    assign w_sel  = (w_empty == 2'b00) ? ~r_last : w_empty[0];
    assign w_rd   = w_load ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge BCclk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_wr[i]) r_mem[i][r_wp[i]] <= w_din[i];
        end
    end

    always_ff @(posedge BCclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_wp[i]   <= '0;
                r_rp[i]   <= '0;
                r_fill[i] <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_wr[i]) r_wp[i] <= r_wp[i] + AW'(1);
                if (w_rd[i]) r_rp[i] <= r_rp[i] + AW'(1);
                if (w_wr[i] && !w_rd[i])
                    r_fill[i] <= r_fill[i] + FW'(1);
                else if (!w_wr[i] && w_rd[i])
                    r_fill[i] <= r_fill[i] - FW'(1);
                // A new drop takes priority over a clear.
                if (w_drop[i])
                    r_ovf[i] <= 1'b1;
                else if (ovf_clr)
                    r_ovf[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge BCclk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_serial <= '0;
            r_dv        <= 1'b0;
            r_last      <= 1'b1;
        end else if (w_load) begin
            r_to_serial <= r_mem[w_sel][r_rp[w_sel]];
            r_dv        <= 1'b1;
            r_last      <= w_sel;
        end else if (ser_ready) begin
            r_dv        <= 1'b0;
        end
    end

    always_ff @(posedge BCclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_enable <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (control != 2'b00) begin
                        r_state  <= ST_RUN;
                        r_enable <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (control == 2'b00) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (control != 2'b00) begin
                        r_state <= ST_RUN;
                    end else if (w_empty == 2'b11 && !r_dv) begin
                        r_state  <= ST_IDLE;
                        r_enable <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    assign to_serial = r_to_serial;
    assign dataV     = r_dv;
    assign enable    = r_enable;
    assign ovf0      = r_ovf[0];
    assign ovf1      = r_ovf[1];
    assign fill0     = r_fill[0];
    assign fill1     = r_fill[1];

endmodule
